fpga_digit_entry: RTL
=====================

Name: fpga_digit_entry

Overview:
- Board-side input path, the reverse of the 7-segment debug display: the user keys a 32-bit hex value into the CPU from switches and push-buttons.
- Raw buttons are synchronised and debounced, then turned into single-cycle press events. Hex nibbles are shifted into an accumulator.
- The accumulator is exposed as `preview` for the digit display. A committed value is offered to the core over a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level change is accepted (≥2).
- DIGITS, 8, number of hex digits in the accumulator; data width = 4*DIGITS.

Ports:
- clock  input  1  single system clock; all logic in this domain.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- sw  input  4  raw hex nibble switches; asynchronous to clock.
- btn_push  input  1  raw button: shift the `sw` nibble into the accumulator.
- btn_commit  input  1  raw button: offer the accumulator to the core.
- btn_clear  input  1  raw button: zero the accumulator.
- preview  output  4*DIGITS  current accumulator contents, for the display.
- digit_count  output  4  digits entered since the last clear, saturates at DIGITS.
- out_data  output  4*DIGITS  committed value.
- out_valid  output  1  `out_data` holds an unconsumed value.
- out_ready  input  1  core accepts `out_data` this cycle.
- drop_flag  output  1  sticky; set when a commit is discarded.

Behaviour:
- **Reset.** Asynchronous, active-low; all flops clear:
  - outputs: `preview`=0, `digit_count`=0, `out_data`=0, `out_valid`=0, `drop_flag`=0;
  - internal state: synchronisers=0, debounced levels=0, debounce counters=0.
  - Reset asserted mid-entry or mid-handshake discards everything; there is no partial state after release.
- **Synchronisers.** `sw[3:0]` and each button pass through two flops.
- **Debounce.** One counter and one stable-level register per button.
  - When the synchronised level equals the stable level, the counter is 0.
  - When they differ, the counter increments each cycle.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, the stable level takes the new value and the counter returns to 0.
  - Any return to the stable level before then zeroes the counter; glitches are ignored.
- **Press event.** Stable level 1 while the previous stable level was 0; exactly one cycle per press. Release produces no event.
- **Latency.** If raw input is first sampled high at edge N and held, the stable level rises at edge N+DEBOUNCE_CYCLES+1. The resulting accumulator or output change is visible after edge N+DEBOUNCE_CYCLES+2.
- **Push event.** `preview` <= {`preview`[4*DIGITS-5:0], sw_sync}, where sw_sync is the synchronised `sw`.
  - The oldest nibble falls off the top.
  - `digit_count` increments, saturating at DIGITS; wrap-around is silent.
- **Clear event.** `preview`=0, `digit_count`=0.
  - Clear has priority over push in the same cycle; that push is lost.
- **Commit event.** Captures `preview` as it was before any same-cycle push or clear; that push or clear still applies to the accumulator. The accumulator is not cleared by a commit.
  - If `out_valid`=0: `out_data` <= `preview`, `out_valid` <= 1 on the next edge.
  - If `out_valid`=1 and `out_ready`=1 in the same cycle: the transfer completes, `out_data` loads the new value, and `out_valid` stays 1.
  - If `out_valid`=1 and `out_ready`=0: the commit is dropped, `out_data` is unchanged, and `drop_flag` <= 1.
- **Handshake.**
  - Transfer occurs on an edge where `out_valid`=1 and `out_ready`=1; with no simultaneous commit, `out_valid` <= 0.
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
  - `out_ready` while `out_valid`=0 has no effect.
- **drop_flag.** Cleared only by reset.

Test Plan:
- **Debounce latency** (DEBOUNCE_CYCLES=4): hold `btn_push` high from edge N with `sw`=0xA. `preview`=0x0000000A and `digit_count`=1 after edge N+6, and no earlier. Holding the button 50 cycles gives exactly one push.
- **Glitch rejection** (DEBOUNCE_CYCLES=4): `btn_push` pulses high for 3 cycles, then low. `preview` stays 0 and `digit_count` stays 0.
- **Entry, wrap and saturation:** push nibbles 1..9 in order. `preview`=0x23456789 and `digit_count`=8. Clear gives `preview`=0 and `digit_count`=0.
- **Handshake:** enter 0xDEADBEEF, commit with `out_ready`=0.
  - `out_valid`=1 and `out_data`=0xDEADBEEF, held for 20 cycles.
  - Raise `out_ready` for 1 cycle: `out_valid`=0 on the next edge.
- **Drop:** with `out_valid`=1 and `out_ready`=0, commit a new value 0x12345678. `out_data` stays 0xDEADBEEF and `drop_flag`=1. A subsequent transfer leaves `drop_flag`=1.
- **Reset mid-operation:** with `out_valid`=1 and `preview`=0xCAFE, pulse reset low asynchronously (between edges). All outputs read 0 immediately, and a held button is not reported as a press until it is released and pressed again.

Source files
------------

// File: rtl/fpga_digit_entry.sv
// fpga_digit_entry
//   Switch/button hex entry path: the user keys a value nibble by nibble,
//   previews it on the digit display and commits it to the core.
//
// Ports
//   clock        system clock, every flop is in this domain
//   reset        asynchronous active-low reset
//   sw           raw hex nibble switches (asynchronous)
//   btn_push     raw button: shift sw into the accumulator
//   btn_commit   raw button: offer the accumulator to the core
//   btn_clear    raw button: zero the accumulator
//   preview      accumulator contents for the display
//   digit_count  digits entered since last clear, saturating at DIGITS
//   out_data     committed value
//   out_valid    out_data holds an unconsumed value
//   out_ready    core accepts out_data this cycle
//   drop_flag    sticky: a commit was discarded while out_data was busy
module fpga_digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DIGITS          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          sw,
    input  logic                btn_push,
    input  logic                btn_commit,
    input  logic                btn_clear,
    output logic [4*DIGITS-1:0] preview,
    output logic [3:0]          digit_count,
    output logic [4*DIGITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                drop_flag
);

    localparam int unsigned W        = 4 * DIGITS;
    localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NB       = 3;
    localparam int unsigned B_PUSH   = 0;
    localparam int unsigned B_COMMIT = 1;
    localparam int unsigned B_CLEAR  = 2;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_s1;
    logic [NB-1:0] btn_s2;
    logic [NB-1:0] stable;
    logic [NB-1:0] stable_d;
    logic [NB-1:0] armed;
    logic [NB-1:0] press;
    logic [CW-1:0] cnt [NB];
    logic [3:0]    sw_s1;
    logic [3:0]    sw_s2;
    logic [1:0]    warm;

    assign btn_raw = {btn_clear, btn_commit, btn_push};

    // Two-flop synchronisers for buttons and switches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: the stable level only follows the synchronised level after
    // DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable   <= '0;
            stable_d <= '0;
            cnt      <= '{default: '0};
        end else begin
            stable_d <= stable;
            for (int unsigned i = 0; i < NB; i++) begin
                if (btn_s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= btn_s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // A button held through reset must not register as a press: each button
    // is armed only once it has been seen released (debounced low and the
    // synchroniser showing a genuine post-reset sample of low).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            warm  <= '0;
            armed <= '0;
        end else begin
            warm <= {warm[0], 1'b1};
            for (int unsigned i = 0; i < NB; i++) begin
                if (warm[1] && !stable[i] && !btn_s2[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    assign press = stable & ~stable_d & armed;

    // Accumulator. Clear wins over a same-cycle push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            preview     <= '0;
            digit_count <= '0;
        end else if (press[B_CLEAR]) begin
            preview     <= '0;
            digit_count <= '0;
        end else if (press[B_PUSH]) begin
            preview <= {preview[W-5:0], sw_s2};
            if (digit_count != 4'(DIGITS)) begin
                digit_count <= digit_count + 4'd1;
            end
        end
    end

    // Output register and handshake. A commit samples the pre-edge preview,
    // so it is unaffected by a push or clear in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            drop_flag <= 1'b0;
        end else if (press[B_COMMIT]) begin
            if (!out_valid || out_ready) begin
                out_data  <= preview;
                out_valid <= 1'b1;
            end else begin
                drop_flag <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
